mem_lsu_initiator: RTL and testbench
====================================

Name: mem_lsu_initiator

Overview:
- CPU-side requester for the single-ported word memory.
- Accepts one load/store at a time from the pipeline and performs byte/halfword/word alignment.
- Drives the memory request channel (valid/ready, word address, data, 4-bit byte write mask) and consumes the read-response channel.
- Returns aligned, sign- or zero-extended load data or a store-complete pulse; misaligned accesses and response timeouts are reported as errors.

Parameters:
- ADDR_BITS, 32, byte address width (`CPU_ADDR_BITS).
- DATA_BITS, 32, CPU data width (`CPU_INST_BITS).
- WORD_ADDR_BITS, ADDR_BITS-2, memory word address width.
- TIMEOUT, 15, maximum cycles spent in WAIT before an error is reported (≥1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- lsu_req_valid  in  1  pipeline request valid.
- lsu_req_ready  out  1  high only in IDLE.
- lsu_req_store  in  1  1 = store, 0 = load.
- lsu_req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_req_addr  in  ADDR_BITS  byte address.
- lsu_req_wdata  in  DATA_BITS  store data, right-aligned.
- lsu_resp_valid  out  1  single-cycle completion pulse.
- lsu_resp_data  out  DATA_BITS  extended load data; 0 for stores and errors.
- lsu_resp_err  out  1  qualifies lsu_resp_valid: misaligned or timeout.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory request ready.
- mem_req_addr  out  WORD_ADDR_BITS  lsu_req_addr[ADDR_BITS-1:2].
- mem_req_data  out  DATA_BITS  lane-replicated store data.
- mem_req_write  out  4  byte write mask; 0 for loads.
- mem_resp_valid  in  1  read response valid.
- mem_resp_data  in  DATA_BITS  read word.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; counter = 0.
  - All outputs 0 except lsu_req_ready = 1.
  - mem_req_valid drops immediately.
  - Any in-flight request is abandoned; no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, on lsu_req_valid & lsu_req_ready:
  - Latch store, funct3, addr, wdata.
  - Misaligned access (H/HU with addr[0] = 1, or W with addr[1:0] != 0): stay in IDLE, issue no memory request, pulse lsu_resp_valid = 1 and lsu_resp_err = 1 next cycle.
  - Unsupported funct3: same handling as misaligned.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req_valid = 1.
  - mem_req_addr, mem_req_data and mem_req_write come from registers and stay stable until mem_req_ready.
  - Store mask: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << addr[1:0]; SW = 4'b1111.
  - Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
  - Load: mem_req_write = 0, mem_req_data = 0.
  - On fire (valid & ready), store: go to IDLE; next cycle lsu_resp_valid = 1, err = 0, data = 0.
  - On fire, load: go to WAIT; counter cleared.
  - No timeout applies while waiting for ready.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid: shift the word right by 8*addr[1:0]; B/H sign-extend bit 7/15, BU/HU zero-extend, W passes through.
  - Then go to IDLE; next cycle lsu_resp_valid = 1, err = 0.
  - If counter reaches TIMEOUT-1 without a response: go to IDLE; next cycle lsu_resp_valid = 1, err = 1, data = 0.
  - mem_resp_valid in the same cycle as expiry: the response wins (err = 0).
- lsu_resp_*:
  - Registered outputs; valid is high exactly one cycle per accepted request.
  - No backpressure on the response.
- mem_resp_valid outside WAIT (late response after timeout, or stray) is ignored with no side effects.
- Memory returns read data 1 cycle after fire, so best-case load latency is accept → ISSUE → WAIT → resp = 3 cycles; store latency is 2 cycles.
- Throughput:
  - A new request may be accepted in the same cycle lsu_resp_valid is high (state is already IDLE).
  - Maximum rate is one request per 2 cycles (stores with ready = 1).

Test Plan:
- Aligned LW at 0x100; memory returns 0xDEADBEEF 1 cycle after fire → mem_req_addr = 0x40, mem_req_write = 0; resp 3 cycles after accept with data 0xDEADBEEF, err 0.
- LB at 0x103 and LBU at 0x103, word 0x80112233 → data 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x22, wdata 0x1234ABCD, mem_req_ready low 3 cycles → valid held with stable addr 0x8, data 0xABCDABCD, mask 4'b1100; one resp pulse (err 0, data 0) the cycle after fire.
- LW at 0x102 → no mem_req_valid; resp next cycle with err 1, data 0; a following aligned SB at 0x103 with wdata 0x5A → mask 4'b1000, data 0x5A5A5A5A.
- LW with no memory response → err 1 exactly TIMEOUT cycles after entering WAIT; a late mem_resp_valid afterwards produces no extra pulse.
- Reset asserted while in WAIT → mem_req_valid and lsu_resp_valid at 0 with no clock edge, lsu_req_ready = 1; after release a new LW completes normally.

Source files
------------

// File: rtl/mem_lsu_initiator_if.sv
// Pipeline-side load/store channel and memory request/response channel of the LSU initiator.
// master = the initiator, slave = the pipeline plus memory that face it.
interface mem_lsu_initiator_if #(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int WORD_ADDR_BITS = ADDR_BITS - 2
);
  logic                      lsu_req_valid;
  logic                      lsu_req_ready;
  logic                      lsu_req_store;
  logic [2:0]                lsu_req_funct3;
  logic [ADDR_BITS-1:0]      lsu_req_addr;
  logic [DATA_BITS-1:0]      lsu_req_wdata;
  logic                      lsu_resp_valid;
  logic [DATA_BITS-1:0]      lsu_resp_data;
  logic                      lsu_resp_err;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [WORD_ADDR_BITS-1:0] mem_req_addr;
  logic [DATA_BITS-1:0]      mem_req_data;
  logic [3:0]                mem_req_write;
  logic                      mem_resp_valid;
  logic [DATA_BITS-1:0]      mem_resp_data;

  modport master (
    input  lsu_req_valid, lsu_req_store, lsu_req_funct3, lsu_req_addr, lsu_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_write
  );

  modport slave (
    output lsu_req_valid, lsu_req_store, lsu_req_funct3, lsu_req_addr, lsu_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_write
  );
endinterface

// File: rtl/mem_lsu_initiator.sv
// CPU-side load/store requester for a single-ported word memory: byte-lane alignment,
// load extension, misalignment and response-timeout errors, one request in flight.
module mem_lsu_initiator #(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int WORD_ADDR_BITS = ADDR_BITS - 2,
  parameter int TIMEOUT        = 15
) (
  input  logic                clk,
  input  logic                reset,
  mem_lsu_initiator_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic                      store_q;
  logic [2:0]                funct3_q;
  logic [1:0]                lane_q;
  logic [WORD_ADDR_BITS-1:0] mem_addr_q;
  logic [DATA_BITS-1:0]      mem_data_q;
  logic [3:0]                mem_mask_q;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic [DATA_BITS-1:0]      resp_data_q;

  logic                      req_ok;
  logic [3:0]                req_mask;
  logic [DATA_BITS-1:0]      req_data;
  logic [DATA_BITS-1:0]      shifted;
  logic [DATA_BITS-1:0]      load_data;
  logic [1:0]                req_lane;

  assign req_lane = bus.lsu_req_addr[1:0];

  // Request decode: alignment check, byte mask and lane-replicated store data.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_ok   = 1'b0;
    req_mask = 4'b0000;
    req_data = '0;
    case (bus.lsu_req_funct3)
      F_B: begin
        req_ok   = 1'b1;
        req_mask = 4'b0001 << req_lane;
        req_data = {(DATA_BITS/8){bus.lsu_req_wdata[7:0]}};
      end
      F_H: begin
        req_ok   = ~req_lane[0];
        req_mask = 4'b0011 << req_lane;
        req_data = {(DATA_BITS/16){bus.lsu_req_wdata[15:0]}};
      end
      F_W: begin
        req_ok   = (req_lane == 2'b00);
        req_mask = 4'b1111;
        req_data = bus.lsu_req_wdata;
      end
      // Unsigned widths exist only for loads; a store with these codes is rejected.
      F_BU:    req_ok = ~bus.lsu_req_store;
      F_HU:    req_ok = ~bus.lsu_req_store & ~req_lane[0];
      default: req_ok = 1'b0;
    endcase
    if (!bus.lsu_req_store) begin
      req_mask = 4'b0000;
      req_data = '0;
    end
  end

  always_comb begin
    shifted   = bus.mem_resp_data >> {lane_q, 3'b000};
    load_data = '0;
    case (funct3_q)
      F_B:     load_data = {{(DATA_BITS-8){shifted[7]}}, shifted[7:0]};
      F_BU:    load_data = {{(DATA_BITS-8){1'b0}}, shifted[7:0]};
      F_H:     load_data = {{(DATA_BITS-16){shifted[15]}}, shifted[15:0]};
      F_HU:    load_data = {{(DATA_BITS-16){1'b0}}, shifted[15:0]};
      F_W:     load_data = shifted;
      default: load_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_mask_q   <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      case (state)
        IDLE: begin
          if (bus.lsu_req_valid) begin
            store_q    <= bus.lsu_req_store;
            funct3_q   <= bus.lsu_req_funct3;
            lane_q     <= req_lane;
            mem_addr_q <= bus.lsu_req_addr[ADDR_BITS-1:2];
            mem_data_q <= req_data;
            mem_mask_q <= req_mask;
            if (req_ok) begin
              state <= ISSUE;
            end else begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            if (store_q) begin
              state        <= IDLE;
              resp_valid_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= '0;
            end
          end
        end
        WAIT: begin
          // A response arriving in the expiry cycle still completes the load.
          if (bus.mem_resp_valid) begin
            state        <= IDLE;
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_data;
          end else if (cnt == CNT_LAST) begin
            state        <= IDLE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lsu_req_ready  = (state == IDLE);
  assign bus.mem_req_valid  = (state == ISSUE);
  assign bus.mem_req_addr   = mem_addr_q;
  assign bus.mem_req_data   = mem_data_q;
  assign bus.mem_req_write  = mem_mask_q;
  assign bus.lsu_resp_valid = resp_valid_q;
  assign bus.lsu_resp_err   = resp_err_q;
  assign bus.lsu_resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_lsu_initiator.sv
// Directed bench for mem_lsu_initiator: a table of single transactions with exact latency
// checks, plus hand sequences for backpressure, back-to-back issue, timeout and reset.
module tb_mem_lsu_initiator;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mdata;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vt[14];

  mem_lsu_initiator_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();

  mem_lsu_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_req_store  = store;
    bus.lsu_req_funct3 = f3;
    bus.lsu_req_addr   = addr;
    bus.lsu_req_wdata  = wdata;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    logic [31:0] word_addr;
    word_addr = {2'b00, v.addr[31:2]};
    check($sformatf("v%0d_ready", idx), 32'(bus.lsu_req_ready), 32'd1);
    bus.mem_req_ready = 1'b1;
    drive_req(v.store, v.funct3, v.addr, v.wdata);
    tick();
    bus.lsu_req_valid = 1'b0;
    if (v.err) begin
      check($sformatf("v%0d_err_memvalid", idx), 32'(bus.mem_req_valid), 32'd0);
      check($sformatf("v%0d_err_respvalid", idx), 32'(bus.lsu_resp_valid), 32'd1);
      check($sformatf("v%0d_err_flag", idx), 32'(bus.lsu_resp_err), 32'd1);
      check($sformatf("v%0d_err_data", idx), bus.lsu_resp_data, 32'd0);
      check($sformatf("v%0d_err_ready", idx), 32'(bus.lsu_req_ready), 32'd1);
    end else begin
      check($sformatf("v%0d_issue_respvalid", idx), 32'(bus.lsu_resp_valid), 32'd0);
      check($sformatf("v%0d_memvalid", idx), 32'(bus.mem_req_valid), 32'd1);
      check($sformatf("v%0d_memaddr", idx), {2'b00, bus.mem_req_addr}, word_addr);
      check($sformatf("v%0d_memmask", idx), 32'(bus.mem_req_write), 32'(v.exp_mask));
      check($sformatf("v%0d_memdata", idx), bus.mem_req_data, v.exp_mdata);
      check($sformatf("v%0d_busy", idx), 32'(bus.lsu_req_ready), 32'd0);
      tick();
      if (!v.store) begin
        check($sformatf("v%0d_wait_respvalid", idx), 32'(bus.lsu_resp_valid), 32'd0);
        check($sformatf("v%0d_wait_memvalid", idx), 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = v.rdata;
        tick();
        bus.mem_resp_valid = 1'b0;
      end
      check($sformatf("v%0d_respvalid", idx), 32'(bus.lsu_resp_valid), 32'd1);
      check($sformatf("v%0d_resperr", idx), 32'(bus.lsu_resp_err), 32'd0);
      check($sformatf("v%0d_respdata", idx), bus.lsu_resp_data, v.exp_data);
    end
    tick();
    check($sformatf("v%0d_pulse_end", idx), 32'(bus.lsu_resp_valid), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          st    f3      addr         wdata         rdata         err   exp_data      mask     mdata
    vt[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0};
    vt[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
    vt[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 1'b0, 32'h00000080, 4'b0000, 32'h0};
    vt[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80112233, 1'b0, 32'hFFFF8011, 4'b0000, 32'h0};
    vt[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80112233, 1'b0, 32'h00008011, 4'b0000, 32'h0};
    vt[5]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h80112233, 1'b0, 32'h00000022, 4'b0000, 32'h0};
    vt[6]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0};
    vt[7]  = '{1'b1, 3'b000, 32'h103, 32'h5A,       32'h0,        1'b0, 32'h0,        4'b1000, 32'h5A5A5A5A};
    vt[8]  = '{1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0,        1'b0, 32'h0,        4'b1111, 32'hCAFEF00D};
    vt[9]  = '{1'b1, 3'b001, 32'h020, 32'h1234ABCD, 32'h0,        1'b0, 32'h0,        4'b0011, 32'hABCDABCD};
    vt[10] = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0};
    vt[11] = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0};
    vt[12] = '{1'b0, 3'b001, 32'h000, 32'h0,        32'h00007FFF, 1'b0, 32'h00007FFF, 4'b0000, 32'h0};
    vt[13] = '{1'b0, 3'b000, 32'h000, 32'h0,        32'h123456F0, 1'b0, 32'hFFFFFFF0, 4'b0000, 32'h0};

    reset              = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_store  = 1'b0;
    bus.lsu_req_funct3 = 3'b000;
    bus.lsu_req_addr   = 32'h0;
    bus.lsu_req_wdata  = 32'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;

    // Reset state
    #12;
    check("rst_ready", 32'(bus.lsu_req_ready), 32'd1);
    check("rst_memvalid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_respvalid", 32'(bus.lsu_resp_valid), 32'd0);
    check("rst_resperr", 32'(bus.lsu_resp_err), 32'd0);
    check("rst_respdata", bus.lsu_resp_data, 32'd0);
    check("rst_memmask", 32'(bus.mem_req_write), 32'd0);
    check("rst_memdata", bus.mem_req_data, 32'd0);
    check("rst_memaddr", {2'b00, bus.mem_req_addr}, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) run_txn(vt[i], i);

    // SH at 0x22 with three cycles of request backpressure
    bus.mem_req_ready = 1'b0;
    drive_req(1'b1, 3'b001, 32'h22, 32'h1234ABCD);
    tick();
    bus.lsu_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_memvalid", i), 32'(bus.mem_req_valid), 32'd1);
      check($sformatf("bp%0d_memaddr", i), {2'b00, bus.mem_req_addr}, 32'h8);
      check($sformatf("bp%0d_memdata", i), bus.mem_req_data, 32'hABCDABCD);
      check($sformatf("bp%0d_memmask", i), 32'(bus.mem_req_write), 32'hC);
      check($sformatf("bp%0d_respvalid", i), 32'(bus.lsu_resp_valid), 32'd0);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    check("bp_final_memvalid", 32'(bus.mem_req_valid), 32'd1);
    tick();
    check("bp_respvalid", 32'(bus.lsu_resp_valid), 32'd1);
    check("bp_resperr", 32'(bus.lsu_resp_err), 32'd0);
    check("bp_respdata", bus.lsu_resp_data, 32'd0);
    check("bp_memvalid_drop", 32'(bus.mem_req_valid), 32'd0);
    tick();
    check("bp_pulse_end", 32'(bus.lsu_resp_valid), 32'd0);

    // Misaligned LW, then SB accepted in the same cycle as the error pulse
    drive_req(1'b0, 3'b010, 32'h102, 32'h0);
    tick();
    check("b2b_err_valid", 32'(bus.lsu_resp_valid), 32'd1);
    check("b2b_err_flag", 32'(bus.lsu_resp_err), 32'd1);
    check("b2b_err_memvalid", 32'(bus.mem_req_valid), 32'd0);
    check("b2b_ready", 32'(bus.lsu_req_ready), 32'd1);
    drive_req(1'b1, 3'b000, 32'h103, 32'h5A);
    tick();
    bus.lsu_req_valid = 1'b0;
    check("b2b_sb_memvalid", 32'(bus.mem_req_valid), 32'd1);
    check("b2b_sb_mask", 32'(bus.mem_req_write), 32'h8);
    check("b2b_sb_data", bus.mem_req_data, 32'h5A5A5A5A);
    tick();
    check("b2b_sb_respvalid", 32'(bus.lsu_resp_valid), 32'd1);
    check("b2b_sb_resperr", 32'(bus.lsu_resp_err), 32'd0);
    tick();

    // Load timeout, then a late response that must be ignored
    drive_req(1'b0, 3'b010, 32'h40, 32'h0);
    tick();
    bus.lsu_req_valid = 1'b0;
    tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      check($sformatf("to_quiet%0d", k), 32'(bus.lsu_resp_valid), 32'd0);
    end
    tick();
    check("to_respvalid", 32'(bus.lsu_resp_valid), 32'd1);
    check("to_resperr", 32'(bus.lsu_resp_err), 32'd1);
    check("to_respdata", bus.lsu_resp_data, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hFFFFFFFF;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("late_novalid0", 32'(bus.lsu_resp_valid), 32'd0);
    tick();
    check("late_novalid1", 32'(bus.lsu_resp_valid), 32'd0);
    check("late_ready", 32'(bus.lsu_req_ready), 32'd1);
    check("late_memvalid", 32'(bus.mem_req_valid), 32'd0);

    // Reset asserted while a load is in WAIT
    drive_req(1'b0, 3'b010, 32'h80, 32'h0);
    tick();
    bus.lsu_req_valid = 1'b0;
    tick();
    tick();
    check("rw_busy", 32'(bus.lsu_req_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("rw_ready", 32'(bus.lsu_req_ready), 32'd1);
    check("rw_memvalid", 32'(bus.mem_req_valid), 32'd0);
    check("rw_respvalid", 32'(bus.lsu_resp_valid), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Reset asserted while a request is held in ISSUE
    bus.mem_req_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h80, 32'h0);
    tick();
    bus.lsu_req_valid = 1'b0;
    check("ri_memvalid_before", 32'(bus.mem_req_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ri_memvalid", 32'(bus.mem_req_valid), 32'd0);
    check("ri_ready", 32'(bus.lsu_req_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("ri_no_resp", 32'(bus.lsu_resp_valid), 32'd0);

    // Normal load after reset release
    run_txn(vt[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
